rv_lsu: RTL and testbench
=========================

# rv_lsu

- Load/store unit: the initiator side of the 64-bit data-memory port (`addr`, `wr_en`, `wr_strobe`, `wr_data`, `rd_en`, `rd_data`).
- Accepts one RV64 load/store per handshake from the execute stage and converts the byte address to a doubleword index.
- Drives the memory port: generates byte strobes and lane-aligned write data, and captures the read data returned one cycle after `rd_en`.
- Extracts, sign- or zero-extends and returns load results to writeback.

## Interface
- `MEM_RD_LAT`, 1: memory read latency in cycles. Fixed at 1; any other value is a `$error` at elaboration.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: high only in IDLE.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RISC-V load/store funct3.
- `req_addr_i` in 64: byte address.
- `req_wdata_i` in 64: store data, right-justified.
- `req_rd_i` in 5: destination register tag.
- `resp_valid_o` out 1: load result valid, one-cycle pulse.
- `resp_rdata_o` out 64: extended load result.
- `resp_rd_o` out 5: tag echoed from the request.
- `err_o` out 1: one-cycle pulse for an illegal or disallowed access.
- `mem_addr_o` out 64: doubleword index `{3'b0, addr[63:3]}`.
- `mem_wr_en_o` out 1: memory write enable.
- `mem_wr_strobe_o` out 8: byte-lane write strobes.
- `mem_wr_data_o` out 64: lane-aligned write data.
- `mem_rd_en_o` out 1: memory read enable.
- `mem_rd_data_i` in 64: memory read data, valid the cycle after `mem_rd_en_o`.

## Operation
- **Request decode:** `o = addr[2:0]`, `s = 1 << funct3[1:0]` bytes, `uns = funct3[2]`.
- **Illegal requests:** funct3 = 3'b111, or a store with `funct3[2] = 1`. No memory access; `err_o` pulses.
- **Split decision:** `split = (o + s > 8)`. A split access uses two beats; otherwise one beat.
- **Beat 1:**
  - Index `addr[63:3]`.
  - Strobe `(((1<<s)-1) << o)[7:0]`.
  - Data `wdata << 8*o`.
- **Beat 2:**
  - Index `addr[63:3] + 1`, wrapping modulo 2^61.
  - Strobe `((1<<s)-1) >> (8-o)`.
  - Data `wdata >> 8*(8-o)`.
- **Load result:** `({hi, lo} >> 8*o)`, keep the low `s` bytes, then sign-extend (`uns = 0`) or zero-extend (`uns = 1`) to 64 bits. `hi = 0` when the access is not split.
- **States:** IDLE, A1, W1, A2, W2, RSP, ERR.
- **Transitions:**
  - IDLE, handshake, illegal → ERR.
  - IDLE, handshake, legal → A1.
  - A1, store → A2 if split, else IDLE.
  - A1, load → W1.
  - W1: capture `lo`; → A2 if split, else RSP.
  - A2, store → IDLE.
  - A2, load → W2.
  - W2: capture `hi`; → RSP.
  - RSP → IDLE.
  - ERR → IDLE.
- **Registers:** request fields are latched at the handshake. `mem_*` outputs are registered and asserted only in A1 and A2; `mem_addr`, `mem_wr_strobe` and `mem_wr_data` hold their last values otherwise.
- **Concurrency:** the `req_valid_i` / `req_ready_o` handshake accepts one request at a time, so a new request cannot arrive while another is in flight.
- **Reset:**
  - All outputs are 0 except `req_ready_o = 1`.
  - State goes to IDLE.
  - Assertion mid-operation abandons the access immediately (asynchronous): no response and no error, and `mem_wr_en_o` falls without waiting for a clock edge.

## Timing
Handshake in cycle T. Latencies:
- **Aligned store:** `mem_wr_en_o = 1` in T+1; ready again in T+2.
- **Split store:** writes in T+1 and T+2; ready in T+3.
- **Aligned load:** `mem_rd_en_o` in T+1, data captured in T+2, `resp_valid_o` in T+3, ready in T+4.
- **Split load:** reads in T+1 and T+3, `resp_valid_o` in T+5, ready in T+6.
- **Error:** `err_o` in T+1; ready in T+2.
- **Response hold:** `resp_rdata_o` and `resp_rd_o` are valid with the pulse and hold until the next response.

## Configuration
- Macro: `RV_LSU_MISALIGN_EN`.
- **Defined:** misaligned accesses are supported as described above, single-beat within a doubleword and two-beat across a doubleword boundary.
- **Undefined:**
  - Any access with `o & (s-1) != 0` is treated as illegal (ERR path, `err_o` pulse, no memory access).
  - States A2 and W2 are not generated.

## Test plan
- SD, addr `0x1008`, data `0x1122334455667788` → T+1: `mem_addr = 0x201`, strobe `0xFF`, `wr_en = 1`, data `0x1122334455667788`.
- SB, addr `0x0003`, data `0xAB`, then LB same address with memory lane 3 = `0xAB` → strobe `0x08`, data `0xAB000000`. Load returns `0xFFFFFFFFFFFFFFAB` at T+3; LBU returns `0xAB`.
- LW, addr `0x0006`, with `RV_LSU_MISALIGN_EN`; mem[0] = `0xBBAA000000000000`, mem[1] = `0x00000000000000DDCC` → reads at indices 0 then 1. Response `0xFFFFFFFFDDCCBBAA` at T+5.
- Same LW without the macro → `err_o` at T+1; no `mem_rd_en_o`; ready at T+2.
- SH, addr `0x0FFF` (macro on), data `0x1234` → beat 1: index `0x1FF`, strobe `0x80`, data byte `0x34`. Beat 2: index `0x200`, strobe `0x01`, data byte `0x12`.
- funct3 = 111 load → `err_o` pulse. Separately, `rst_n` low during W1 of an LD → all outputs 0 asynchronously; no response after reset release.

Source files
------------

// File: rtl/rv_lsu.sv
// rv_lsu: RV64 load/store unit, initiator of a 64-bit doubleword-indexed data memory port.
// Define RV_LSU_MISALIGN_EN to allow misaligned accesses (two beats across a doubleword boundary).
module rv_lsu #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic [4:0]  resp_rd_o,
    output logic        err_o,
    output logic [63:0] mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [7:0]  mem_wr_strobe_o,
    output logic [63:0] mem_wr_data_o,
    output logic        mem_rd_en_o,
    input  logic [63:0] mem_rd_data_i
);
    // Read data is captured in the W states, exactly one cycle after the read beat.
    if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
        $error("rv_lsu: MEM_RD_LAT must be 1");
    end

`ifdef RV_LSU_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, A1, W1, A2, W2, RSP, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, A1, W1, RSP, ERR} state_t;
`endif
    state_t state_reg, state_next;

    logic [2:0]  req_off;
    logic [3:0]  req_size;
    logic [7:0]  req_mask;
    logic        req_illegal;
    logic [7:0]  beat1_strobe;
    logic [63:0] beat1_data;
`ifdef RV_LSU_MISALIGN_EN
    logic        req_split;
    logic [7:0]  beat2_strobe;
    logic [63:0] beat2_data;
    logic        split_reg;
    logic [60:0] idx2_reg;
    logic [7:0]  strobe2_reg;
    logic [63:0] data2_reg;
    logic [63:0] lo_reg;
    logic [63:0] load_lo;
    logic [63:0] load_hi;
`else
    logic [3:0]  req_size_m1;
`endif

    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [2:0]  off_reg;
    logic [4:0]  rd_reg;
    logic [63:0] load_shift;
    logic [63:0] load_result;

    logic [63:0] mem_addr_reg;
    logic        mem_wr_en_reg;
    logic [7:0]  mem_wr_strobe_reg;
    logic [63:0] mem_wr_data_reg;
    logic        mem_rd_en_reg;
    logic [63:0] resp_rdata_reg;
    logic [4:0]  resp_rd_reg;

    always_comb begin
        req_off      = req_addr_i[2:0];
        req_size     = 4'd1 << req_funct3_i[1:0];
        req_mask     = 8'((9'd1 << req_size) - 9'd1);
        req_illegal  = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
        beat1_strobe = req_mask << req_off;
        beat1_data   = req_wdata_i << {req_off, 3'b000};
`ifdef RV_LSU_MISALIGN_EN
        req_split    = ({1'b0, req_off} + req_size) > 4'd8;
        beat2_strobe = req_mask >> (4'd8 - {1'b0, req_off});
        beat2_data   = req_wdata_i >> (7'd64 - {1'b0, req_off, 3'b000});
`else
        req_size_m1  = req_size - 4'd1;
        req_illegal  = req_illegal || ((req_off & req_size_m1[2:0]) != 3'b000);
`endif
    end

    // Load path: shift the (hi, lo) pair down to the addressed byte, then extend.
    always_comb begin
`ifdef RV_LSU_MISALIGN_EN
        load_lo    = (state_reg == W1) ? mem_rd_data_i : lo_reg;
        load_hi    = (state_reg == W2) ? mem_rd_data_i : 64'd0;
        load_shift = 64'({load_hi, load_lo} >> {off_reg, 3'b000});
`else
        load_shift = mem_rd_data_i >> {off_reg, 3'b000};
`endif
        case (funct3_reg[1:0])
            2'd0:    load_result = funct3_reg[2] ? {56'd0, load_shift[7:0]}
                                                 : {{56{load_shift[7]}}, load_shift[7:0]};
            2'd1:    load_result = funct3_reg[2] ? {48'd0, load_shift[15:0]}
                                                 : {{48{load_shift[15]}}, load_shift[15:0]};
            2'd2:    load_result = funct3_reg[2] ? {32'd0, load_shift[31:0]}
                                                 : {{32{load_shift[31]}}, load_shift[31:0]};
            default: load_result = load_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid_i) state_next = req_illegal ? ERR : A1;
`ifdef RV_LSU_MISALIGN_EN
            A1:      state_next = we_reg ? (split_reg ? A2 : IDLE) : W1;
            W1:      state_next = split_reg ? A2 : RSP;
            A2:      state_next = we_reg ? IDLE : W2;
            W2:      state_next = RSP;
`else
            A1:      state_next = we_reg ? IDLE : W1;
            W1:      state_next = RSP;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_reg == IDLE);
        resp_valid_o = (state_reg == RSP);
        err_o        = (state_reg == ERR);
    end

    // Memory-port outputs are loaded on the edge entering a beat state, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg            <= 1'b0;
            funct3_reg        <= 3'd0;
            off_reg           <= 3'd0;
            rd_reg            <= 5'd0;
            mem_addr_reg      <= 64'd0;
            mem_wr_en_reg     <= 1'b0;
            mem_wr_strobe_reg <= 8'd0;
            mem_wr_data_reg   <= 64'd0;
            mem_rd_en_reg     <= 1'b0;
            resp_rdata_reg    <= 64'd0;
            resp_rd_reg       <= 5'd0;
`ifdef RV_LSU_MISALIGN_EN
            split_reg         <= 1'b0;
            idx2_reg          <= 61'd0;
            strobe2_reg       <= 8'd0;
            data2_reg         <= 64'd0;
            lo_reg            <= 64'd0;
`endif
        end else begin
            mem_wr_en_reg <= 1'b0;
            mem_rd_en_reg <= 1'b0;
            if (state_reg == IDLE && req_valid_i) begin
                we_reg      <= req_we_i;
                funct3_reg  <= req_funct3_i;
                off_reg     <= req_off;
                rd_reg      <= req_rd_i;
`ifdef RV_LSU_MISALIGN_EN
                split_reg   <= req_split;
                idx2_reg    <= req_addr_i[63:3] + 61'd1;
                strobe2_reg <= beat2_strobe;
                data2_reg   <= beat2_data;
`endif
            end
            if (state_next == A1) begin
                mem_addr_reg      <= {3'b000, req_addr_i[63:3]};
                mem_wr_strobe_reg <= beat1_strobe;
                mem_wr_data_reg   <= beat1_data;
                mem_wr_en_reg     <= req_we_i;
                mem_rd_en_reg     <= ~req_we_i;
            end
`ifdef RV_LSU_MISALIGN_EN
            if (state_next == A2) begin
                mem_addr_reg      <= {3'b000, idx2_reg};
                mem_wr_strobe_reg <= strobe2_reg;
                mem_wr_data_reg   <= data2_reg;
                mem_wr_en_reg     <= we_reg;
                mem_rd_en_reg     <= ~we_reg;
            end
            if (state_reg == W1) begin
                lo_reg <= mem_rd_data_i;
            end
`endif
            if (state_next == RSP) begin
                resp_rdata_reg <= load_result;
                resp_rd_reg    <= rd_reg;
            end
        end
    end

    assign mem_addr_o      = mem_addr_reg;
    assign mem_wr_en_o     = mem_wr_en_reg;
    assign mem_wr_strobe_o = mem_wr_strobe_reg;
    assign mem_wr_data_o   = mem_wr_data_reg;
    assign mem_rd_en_o     = mem_rd_en_reg;
    assign resp_rdata_o    = resp_rdata_reg;
    assign resp_rd_o       = resp_rd_reg;
endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: directed cases and random traffic checked against a byte-addressed
// reference memory; a 32-doubleword byte memory serves the DUT's memory port.
module tb_rv_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        resp_valid_o;
    logic [63:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic        err_o;
    logic [63:0] mem_addr_o;
    logic        mem_wr_en_o;
    logic [7:0]  mem_wr_strobe_o;
    logic [63:0] mem_wr_data_o;
    logic        mem_rd_en_o;
    logic [63:0] mem_rd_data_i;

    always #5 clk = ~clk;

    rv_lsu #(.MEM_RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_rd_o(resp_rd_o), .err_o(err_o), .mem_addr_o(mem_addr_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_wr_strobe_o(mem_wr_strobe_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rd_en_o(mem_rd_en_o), .mem_rd_data_i(mem_rd_data_i)
    );

    logic [7:0]  dev_mem [256];
    logic [7:0]  ref_mem [256];
    logic [63:0] last_resp;
    logic [4:0]  last_rd;
    int          n_assert = 0;
    int          n_fail = 0;

    // Memory device: 1-cycle registered read, byte-strobed write; index aliases modulo 32.
    initial begin
        logic [63:0] row;
        mem_rd_data_i = 64'd0;
        for (int i = 0; i < 256; i++) dev_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (mem_wr_en_o)
                for (int l = 0; l < 8; l++)
                    if (mem_wr_strobe_o[l]) dev_mem[{mem_addr_o[4:0], 3'(l)}] = mem_wr_data_o[8*l +: 8];
            if (mem_rd_en_o) begin
                for (int l = 0; l < 8; l++) row[8*l +: 8] = dev_mem[{mem_addr_o[4:0], 3'(l)}];
                mem_rd_data_i <= row;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, req_ready_o, 1);
        chk({tag, "_resp_valid"}, resp_valid_o, 0);
        chk({tag, "_resp_rdata"}, resp_rdata_o, 0);
        chk({tag, "_resp_rd"}, resp_rd_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_wr_en"}, mem_wr_en_o, 0);
        chk({tag, "_strobe"}, mem_wr_strobe_o, 0);
        chk({tag, "_wr_data"}, mem_wr_data_o, 0);
        chk({tag, "_rd_en"}, mem_rd_en_o, 0);
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [4:0] rd, output logic [63:0] resp);
        int          s, o, n_beats, ready_k, resp_k, j, pos;
        bit          illegal, split;
        logic [7:0]  exp_strb [2];
        logic [63:0] exp_data [2];
        logic [63:0] exp_idx [2];
        int          beat_k [2];
        logic [63:0] val, lane_mask;
        logic [7:0]  ba;
        s = 1 << f3[1:0];
        o = int'(a[2:0]);
        illegal = (f3 == 3'b111) || (we && f3[2]);
`ifndef RV_LSU_MISALIGN_EN
        if ((a % 64'(s)) != 64'd0) illegal = 1'b1;
`endif
        split = !illegal && (o + s > 8);
        exp_strb = '{8'd0, 8'd0};
        exp_data = '{64'd0, 64'd0};
        for (int b = 0; b < s; b++) begin
            pos = o + b;
            exp_strb[pos / 8][pos % 8] = 1'b1;
            exp_data[pos / 8][8*(pos % 8) +: 8] = wd[8*b +: 8];
        end
        exp_idx[0] = a / 64'd8;
        exp_idx[1] = (a / 64'd8 + 64'd1) & ((64'd1 << 61) - 64'd1);
        val = 64'd0;
        for (int b = 0; b < s; b++) begin
            ba = a[7:0] + 8'(b);
            val[8*b +: 8] = ref_mem[ba];
        end
        if (!f3[2]) for (int i = 8 * s; i < 64; i++) val[i] = val[8*s-1];
        n_beats = illegal ? 0 : (split ? 2 : 1);
        resp_k = 0;
        if (illegal) begin
            beat_k = '{0, 0}; ready_k = 2;
        end else if (we) begin
            beat_k = '{1, 2}; ready_k = split ? 3 : 2;
        end else begin
            beat_k = '{1, 3}; resp_k = split ? 5 : 3; ready_k = resp_k + 1;
        end

        @(negedge clk);
        chk("ready_before", req_ready_o, 1);
        chk("resp_rdata_hold", resp_rdata_o, last_resp);
        chk("resp_rd_hold", resp_rd_o, 64'(last_rd));
        req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_we_i = 1'($urandom); req_funct3_i = 3'($urandom); req_addr_i = {$urandom, $urandom};
        req_wdata_i = {$urandom, $urandom}; req_rd_i = 5'($urandom);
        for (int k = 1; k <= ready_k; k++) begin
            @(negedge clk);
            j = (n_beats > 0 && k == beat_k[0]) ? 0 : ((n_beats > 1 && k == beat_k[1]) ? 1 : -1);
            chk($sformatf("ready_T+%0d", k), req_ready_o, 64'(k == ready_k));
            chk($sformatf("wr_en_T+%0d", k), mem_wr_en_o, 64'(j >= 0 && we));
            chk($sformatf("rd_en_T+%0d", k), mem_rd_en_o, 64'(j >= 0 && !we));
            chk($sformatf("err_T+%0d", k), err_o, 64'(illegal && k == 1));
            chk($sformatf("resp_valid_T+%0d", k), resp_valid_o, 64'(k == resp_k));
            if (j >= 0) begin
                chk($sformatf("mem_addr_beat%0d", j + 1), mem_addr_o, exp_idx[j]);
                if (we) begin
                    chk($sformatf("strobe_beat%0d", j + 1), mem_wr_strobe_o, 64'(exp_strb[j]));
                    lane_mask = 64'd0;
                    for (int l = 0; l < 8; l++) if (exp_strb[j][l]) lane_mask[8*l +: 8] = 8'hFF;
                    chk($sformatf("wr_data_beat%0d", j + 1), mem_wr_data_o & lane_mask, exp_data[j]);
                end
            end
            if (k == resp_k) begin
                chk("resp_rdata", resp_rdata_o, val);
                chk("resp_rd", resp_rd_o, 64'(rd));
                last_resp = val;
                last_rd = rd;
            end
        end
        if (!illegal && we)
            for (int b = 0; b < s; b++) begin
                ba = a[7:0] + 8'(b);
                ref_mem[ba] = wd[8*b +: 8];
            end
        resp = (!illegal && !we) ? val : 64'd0;
        $display("req we=%0d f3=%0d addr=0x%h wdata=0x%h -> %s result=0x%h", we, f3, a, wd,
                 illegal ? "error" : (split ? "split" : "single"), resp);
    endtask

    // Abandon a doubleword access with an asynchronous reset at cycle T+at_k.
    task automatic reset_mid(input logic we, input int at_k);
        @(negedge clk);
        req_we_i = we; req_funct3_i = 3'b011; req_addr_i = 64'h40;
        req_wdata_i = {$urandom, $urandom}; req_rd_i = 5'd7; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= at_k; k++) @(negedge clk);
        chk("busy_before_rst", req_ready_o, 0);
        if (at_k == 1) chk("enable_before_rst", we ? mem_wr_en_o : mem_rd_en_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_idle(we ? "async_rst_store" : "async_rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        last_resp = 64'd0;
        last_rd = 5'd0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_resp_valid", resp_valid_o, 0);
            chk("post_rst_err", err_o, 0);
            chk("post_rst_ready", req_ready_o, 1);
            chk("post_rst_wr_en", mem_wr_en_o, 0);
            chk("post_rst_rd_en", mem_rd_en_o, 0);
        end
        $display("reset during %s at T+%0d: access abandoned", we ? "store" : "load", at_k);
    endtask

    initial begin
        logic [63:0] r;
        logic        we;
        logic [2:0]  f3;
        logic [63:0] a;
        rst_n = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
        req_addr_i = 64'd0; req_wdata_i = 64'd0; req_rd_i = 5'd0;
        last_resp = 64'd0;
        last_rd = 5'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        run_req(1'b1, 3'b011, 64'h1008, 64'h1122334455667788, 5'd1, r);
        run_req(1'b1, 3'b000, 64'h3, 64'hAB, 5'd2, r);
        run_req(1'b0, 3'b000, 64'h3, 64'h0, 5'd3, r);
        chk("plan_lb", r, 64'hFFFFFFFFFFFFFFAB);
        run_req(1'b0, 3'b100, 64'h3, 64'h0, 5'd4, r);
        chk("plan_lbu", r, 64'hAB);
        run_req(1'b1, 3'b011, 64'h0, 64'hBBAA000000000000, 5'd5, r);
        run_req(1'b1, 3'b011, 64'h8, 64'hDDCC, 5'd6, r);
        run_req(1'b0, 3'b010, 64'h6, 64'h0, 5'd7, r);
`ifdef RV_LSU_MISALIGN_EN
        chk("plan_lw_split", r, 64'hFFFFFFFFDDCCBBAA);
`endif
        run_req(1'b1, 3'b001, 64'hFFF, 64'h1234, 5'd8, r);
        run_req(1'b0, 3'b101, 64'hFFF, 64'h0, 5'd9, r);
        run_req(1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5678, 5'd10, r);
        run_req(1'b0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd11, r);
        run_req(1'b0, 3'b111, 64'h10, 64'h0, 5'd12, r);
        run_req(1'b1, 3'b100, 64'h10, 64'h55, 5'd13, r);
        reset_mid(1'b1, 1);
        reset_mid(1'b0, 2);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a = ($urandom % 4 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            if ($urandom % 2 == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            run_req(we, f3, a, {$urandom, $urandom}, 5'($urandom), r);
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) chk($sformatf("mem_byte_%0d", i), dev_mem[i], ref_mem[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
